serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result bit width (legal range 1..64).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request to begin an addition; sampled on clk.
REQ-005 SHALL have port a  input  WIDTH  operand A, captured on accepted start.
REQ-006 SHALL have port b  input  WIDTH  operand B, captured on accepted start.
REQ-007 SHALL have port c  input  1  carry-in, captured on accepted start.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking a new valid result.
REQ-010 SHALL have port sum  output  WIDTH  result of last completed operation.
REQ-011 SHALL have port carry  output  1  carry-out of last completed operation.
REQ-012 SHALL have port overflow  output  1  signed overflow of last completed operation.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; busy = (state==RUN).
REQ-014 SHALL accept start only in IDLE or DONE; on acceptance capture a, b, c into shift/carry registers, clear bit counter, go to RUN.
REQ-015 SHALL ignore start while in RUN; captured operands are unaffected.
REQ-016 SHALL in RUN process exactly one bit per cycle, LSB first, through one full-adder cell, the carry held in a flip-flop between bits.
REQ-017 SHALL leave RUN after exactly WIDTH RUN edges; done high in the cycle after the WIDTH-th RUN edge (capture edge + WIDTH edges).
REQ-018 SHALL update sum, carry, overflow only on the RUN->DONE edge; they hold their values otherwise, including through the next operation.
REQ-019 SHALL compute overflow = carry into MSB XOR carry out of MSB; for WIDTH=1 overflow = c XOR carry.
REQ-020 SHALL go DONE->RUN if start=1 in DONE (back-to-back, no idle cycle), else DONE->IDLE; done therefore never high two consecutive cycles.
REQ-021 SHALL produce results equal to (a + b + c) mod 2^WIDTH, with carry as bit WIDTH of the exact sum.

Reset
REQ-022 SHALL on rst=1 immediately force state IDLE, busy=0, done=0, sum=0, carry=0, overflow=0, counter and shift registers 0.
REQ-023 SHALL abort an in-progress operation on reset mid-RUN with no done pulse and no result update.
REQ-024 SHALL accept start on the first rising edge after rst deasserts.

Configuration
REQ-025 SHALL recognise macro SERIAL_ADDER_SUB_EN; when defined, add port sub  input  1, captured on accepted start.
REQ-026 SHALL with SERIAL_ADDER_SUB_EN and sub=1 compute a - b as a + ~b + 1 (c ignored, carry=1 means no borrow); sub=0 behaves as REQ-021.
REQ-027 SHALL without SERIAL_ADDER_SUB_EN have no sub port and perform addition only.

Structure
REQ-028 SHALL place the FSM state typedef/encoding, default WIDTH constant and counter-width (clog2) helper in package serial_adder_pkg.
REQ-029 SHALL instantiate a combinational sub-module fa_cell (a, b, c -> sum, carry) for the per-bit add.

Verification
REQ-030 SHALL cover WIDTH=8: a=0x5A, b=0x3C, c=0 -> done 8 edges after capture, sum=0x96, carry=0, overflow=1.
REQ-031 SHALL cover wrap: a=0xFF, b=0x01, c=0 -> sum=0x00, carry=1, overflow=0; a=0xFF, b=0xFF, c=1 -> sum=0xFF, carry=1, overflow=0.
REQ-032 SHALL cover back-to-back: start held high across DONE -> second op starts with no IDLE cycle, two single-cycle done pulses 9 cycles apart, start during RUN ignored.
REQ-033 SHALL cover reset mid-RUN: rst pulsed at bit 4 -> busy=0, no done, sum/carry/overflow=0, next op 0x01+0x01 -> 0x02.
REQ-034 SHALL cover SERIAL_ADDER_SUB_EN: sub=1, 0x10-0x20 -> 0xF0, carry=0; 0x80-0x01 -> 0x7F, carry=1, overflow=1.
REQ-035 SHALL cover WIDTH=1 exhaustively (8 combinations of a, b, c) against full-adder truth table, done 1 edge after capture.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM encoding, default operand width and counter sizing
package serial_adder_pkg;
    typedef logic [1:0] state_t;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam int DEFAULT_WIDTH = 8;
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction
endpackage

// File: rtl/fa_cell.sv
// fa_cell: combinational one-bit full adder
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one bit per cycle LSB first.
// Define SERIAL_ADDER_SUB_EN to add a sub port selecting a - b.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);
    localparam int CW = cnt_width(WIDTH);
    state_t           state;
    logic [WIDTH-1:0] sa, sb, bin;
    logic [WIDTH:0]   sh;
    logic [CW-1:0]    cnt;
    logic             cr, s, co, cin, take, last;
`ifdef SERIAL_ADDER_SUB_EN
    assign bin = sub ? ~b : b;
    assign cin = sub | c;
`else
    assign bin = b;
    assign cin = c;
`endif
    fa_cell u_fa (.a(sa[0]), .b(sb[0]), .c(cr), .sum(s), .carry(co));
    // result bits enter at the top of the A register as its bits are consumed
    assign sh   = {s, sa};
    assign take = start && state != RUN;
    assign last = cnt == CW'(WIDTH - 1);
    assign busy = state == RUN;
    assign done = state == DONE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sa       <= '0;
            sb       <= '0;
            cr       <= 1'b0;
            cnt      <= '0;
            sum      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else if (take) begin
            sa    <= a;
            sb    <= bin;
            cr    <= cin;
            cnt   <= '0;
            state <= RUN;
        end else if (state == RUN) begin
            sa  <= sh[WIDTH:1];
            sb  <= sb >> 1;
            cr  <= co;
            cnt <= cnt + CW'(1);
            if (last) begin
                state    <= DONE;
                sum      <= sh[WIDTH:1];
                carry    <= co;
                overflow <= cr ^ co;
            end
        end else begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized and directed checks of serial_adder (WIDTH=8 and WIDTH=1)
module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, sub = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       c = 1'b0;
    logic       busy, done, carry, overflow;
    logic [7:0] sum;
    logic       start1 = 1'b0, sub1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0, sum1;
    logic       c1 = 1'b0;
    logic       busy1, done1, carry1, overflow1;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .a(a), .b(b), .c(c), .busy(busy), .done(done),
        .sum(sum), .carry(carry), .overflow(overflow)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub1),
`endif
        .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1),
        .sum(sum1), .carry(carry1), .overflow(overflow1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {overflow, carry, sum} from plain arithmetic; overflow = operand signs agree, result sign differs
    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic ci, input logic sb);
        logic [7:0] yy;
        logic [8:0] full;
        yy   = sb ? ~y : y;
        full = {1'b0, x} + {1'b0, yy} + {8'd0, sb ? 1'b1 : ci};
        return {(x[7] == yy[7]) && (full[7] != x[7]), full};
    endfunction

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run8(input string tag, input logic [7:0] x, input logic [7:0] y, input logic ci, input logic sb);
        logic [9:0] e;
        int n;
        e = model(x, y, ci, sb);
        @(negedge clk);
        start = 1'b1; a = x; b = y; c = ci; sub = sb;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, busy, 1);
        wait_done(n);
        check({tag, "_lat"}, n, 8);
        check({tag, "_sum"}, sum, e[7:0]);
        check({tag, "_carry"}, carry, e[8]);
        check({tag, "_ovf"}, overflow, e[9]);
        check({tag, "_busy_done"}, busy, 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        logic [9:0] r1, r2;
        logic [7:0] x, y;
        logic seen;
        int n, gap;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_carry", carry, 0);
        check("rst_ovf", overflow, 0);
        rst = 1'b0;

        run8("d5a3c", 8'h5A, 8'h3C, 1'b0, 1'b0);
        run8("dff01", 8'hFF, 8'h01, 1'b0, 1'b0);
        run8("dffff1", 8'hFF, 8'hFF, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++)
            run8("rnd", 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);

        // back-to-back with start held high; operands changed while running must be ignored
        r1 = model(8'h12, 8'h34, 1'b1, 1'b0);
        r2 = model(8'hC3, 8'hA7, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b1; a = 8'h12; b = 8'h34; c = 1'b1; sub = 1'b0;
        @(negedge clk);
        a = 8'hC3; b = 8'hA7; c = 1'b0;
        wait_done(n);
        check("b2b_lat1", n, 8);
        check("b2b_sum1", sum, r1[7:0]);
        check("b2b_carry1", carry, r1[8]);
        @(negedge clk);
        start = 1'b0;
        check("b2b_nodone", done, 0);
        check("b2b_noidle", busy, 1);
        check("b2b_hold", sum, r1[7:0]);
        gap = 1;
        while (!done && gap < 30) begin
            @(negedge clk);
            gap++;
        end
        check("b2b_gap", gap, 9);
        check("b2b_sum2", sum, r2[7:0]);
        check("b2b_carry2", carry, r2[8]);
        check("b2b_ovf2", overflow, r2[9]);

        // reset in the middle of an operation
        run8("pre_rst", 8'hF0, 8'h0F, 1'b1, 1'b0);
        @(negedge clk);
        start = 1'b1; a = 8'hAA; b = 8'h55; c = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_busy", busy, 0);
        check("mid_done", done, 0);
        check("mid_sum", sum, 0);
        check("mid_carry", carry, 0);
        check("mid_ovf", overflow, 0);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen |= done;
        end
        check("mid_nodone", seen, 0);
        // release reset together with start so the first edge after release captures
        start = 1'b1; a = 8'h01; b = 8'h01; c = 1'b0; rst = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("post_busy", busy, 1);
        wait_done(n);
        check("post_lat", n, 8);
        check("post_sum", sum, 8'h02);
        check("post_carry", carry, 0);

`ifdef SERIAL_ADDER_SUB_EN
        run8("sub1020", 8'h10, 8'h20, 1'b0, 1'b1);
        check("sub1020_v", sum, 8'hF0);
        run8("sub8001", 8'h80, 8'h01, 1'b1, 1'b1);
        check("sub8001_v", {overflow, carry, sum}, {2'b11, 8'h7F});
        for (int i = 0; i < 10; i++)
            run8("rndsub", 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
`endif

        // WIDTH=1 exhaustive against full-adder truth table
        for (int k = 0; k < 8; k++) begin
            logic [1:0] t;
            t = 2'(k[2]) + 2'(k[1]) + 2'(k[0]);
            @(negedge clk);
            start1 = 1'b1; a1 = k[2]; b1 = k[1]; c1 = k[0];
            @(negedge clk);
            start1 = 1'b0;
            n = 0;
            while (!done1 && n < 10) begin
                @(negedge clk);
                n++;
            end
            check("w1_lat", n, 1);
            check("w1_sum", sum1, t[0]);
            check("w1_carry", carry1, t[1]);
            check("w1_ovf", overflow1, k[0] ^ t[1]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
